// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer: decode-stage instruction trace buffer with PC/forced trigger and class counters
// Define TRACE_CNT_EN to build the 17 per-class saturating counters behind cnt_sel/cnt_out.
module mips_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [PC_W-1:0]        pc_in,
    input  logic [31:0]            instr_in,
    input  logic                   arm,
    input  logic                   trig_en,
    input  logic [PC_W-1:0]        trig_pc,
    input  logic                   force_trig,
    input  logic [$clog2(DEPTH):0] post_count,
    input  logic                   rd_req,
    output logic                   rd_ack,
    output logic [PC_W+4:0]        rd_data,
    output logic                   rd_empty,
    output logic [1:0]             state,
    output logic                   overflow,
    input  logic                   clr_cnt,
    input  logic [4:0]             cnt_sel,
    output logic [CNT_W-1:0]       cnt_out
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [AW:0] FULL     = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] MAX_POST = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

    function automatic logic [4:0] classify(input logic [5:0] op, input logic [5:0] fn);
        logic [4:0] c;
        c = 5'd0;
        if (op == 6'd0) begin
            case (fn)
                6'd0:    c = 5'd1;
                6'd32:   c = 5'd2;
                6'd34:   c = 5'd3;
                6'd36:   c = 5'd4;
                6'd37:   c = 5'd5;
                6'd2:    c = 5'd6;
                6'd42:   c = 5'd7;
                6'd8:    c = 5'd8;
                6'd27:   c = 5'd9;
                6'd16:   c = 5'd10;
                6'd18:   c = 5'd11;
                default: c = 5'd0;
            endcase
        end else begin
            case (op)
                6'd35:   c = 5'd12;
                6'd43:   c = 5'd13;
                6'd4:    c = 5'd14;
                6'd2:    c = 5'd15;
                6'd13:   c = 5'd16;
                default: c = 5'd0;
            endcase
        end
        return c;
    endfunction

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW:0]     fill_q, fill_d;
    logic [AW:0]     rcnt_q, rcnt_d;
    logic [AW:0]     post_q, post_d;
    logic            ovf_q, ovf_d;
    logic            ack_q, ack_d;
    logic            empty_q, empty_d;
    logic [PC_W+4:0] data_q, data_d;
    logic [PC_W+4:0] mem_q [DEPTH];
    logic [4:0]      cls;
    logic            capture, trig, rd_go;
    logic [AW:0]     eff_post;
    logic [AW-1:0]   rd_idx;

    assign cls      = classify(instr_in[31:26], instr_in[5:0]);
    assign capture  = valid_in && !arm && (state_q == S_ARMED || state_q == S_POST);
    assign trig     = force_trig || (trig_en && pc_in == trig_pc);
    assign eff_post = post_count > MAX_POST ? MAX_POST : post_count;
    assign rd_go    = !arm && state_q == S_DONE && rd_req && !empty_q;
    // oldest surviving entry sits fill_q slots behind the write pointer
    assign rd_idx   = wptr_q - fill_q[AW-1:0] + rcnt_q[AW-1:0];

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        fill_d  = fill_q;
        post_d  = post_q;
        ovf_d   = ovf_q;
        ack_d   = rd_go;
        data_d  = rd_go ? mem_q[rd_idx] : data_q;
        rcnt_d  = rd_go ? rcnt_q + 1'b1 : rcnt_q;
        if (arm) begin
            state_d = S_ARMED;
            wptr_d  = '0;
            fill_d  = '0;
            rcnt_d  = '0;
            ovf_d   = 1'b0;
        end else if (capture) begin
            wptr_d = wptr_q + 1'b1;
            fill_d = fill_q == FULL ? FULL : fill_q + 1'b1;
            ovf_d  = ovf_q || fill_q == FULL;
            if (state_q == S_ARMED && trig) begin
                post_d  = eff_post;
                state_d = eff_post == '0 ? S_DONE : S_POST;
            end else if (state_q == S_POST) begin
                post_d  = post_q - 1'b1;
                state_d = post_q == ONE ? S_DONE : S_POST;
            end
        end
        empty_d = rcnt_d == fill_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            fill_q  <= '0;
            rcnt_q  <= '0;
            post_q  <= '0;
            ovf_q   <= 1'b0;
            ack_q   <= 1'b0;
            empty_q <= 1'b1;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            fill_q  <= fill_d;
            rcnt_q  <= rcnt_d;
            post_q  <= post_d;
            ovf_q   <= ovf_d;
            ack_q   <= ack_d;
            empty_q <= empty_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) mem_q[wptr_q] <= {cls, pc_in};
    end

    assign state    = state_q;
    assign overflow = ovf_q;
    assign rd_ack   = ack_q;
    assign rd_data  = data_q;
    assign rd_empty = empty_q;

`ifdef TRACE_CNT_EN
    logic [CNT_W-1:0] cnt_q [17];
    logic             unused_bits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 17; i++) cnt_q[i] <= '0;
        end else if (clr_cnt) begin
            for (int i = 0; i < 17; i++) cnt_q[i] <= '0;
        end else if (valid_in && cnt_q[cls] != '1) begin
            cnt_q[cls] <= cnt_q[cls] + 1'b1;
        end
    end

    assign cnt_out     = cnt_sel <= 5'd16 ? cnt_q[cnt_sel] : '0;
    assign unused_bits = ^instr_in[25:6];
`else
    logic unused_bits;

    assign cnt_out     = '0;
    assign unused_bits = ^{instr_in[25:6], clr_cnt, cnt_sel};
`endif
endmodule
